execute_cycle: RTL and testbench
================================

# execute_cycle

Execute stage of the five-stage RISC-V pipeline. Consumes the registered decode-to-execute bundle, applies operand forwarding, performs the ALU operation and branch resolution, and drives the branch redirect back to fetch. Holds the execute-to-memory pipeline register that feeds the memory stage.

## Interface
Parameters:
- none; all widths fixed: 32-bit data, 5-bit register index, 3-bit ALU control.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears the E/M register.
- RegWriteE  input  1  register-file write enable for the instruction in E.
- ALUSrcE  input  1  0: SrcB is the forwarded RD2; 1: SrcB is Imm_Ext_E.
- MemWriteE  input  1  data-memory write enable.
- ResultSrcE  input  1  0: writeback selects the ALU result; 1: writeback selects memory data.
- BranchE  input  1  the instruction in E is beq.
- ALUControlE  input  3  ALU operation select.
- RD1_E, RD2_E  input  32  register-file read data.
- Imm_Ext_E  input  32  sign-extended immediate.
- RD_E  input  5  destination register index.
- RS1_E, RS2_E  input  5  source register indices, passed through for the hazard unit.
- PCE, PCPlus4E  input  32  PC of the instruction and PC+4.
- ForwardAE, ForwardBE  input  2  forwarding selects from the hazard unit.
- ResultW  input  32  writeback-stage result.
- PCSrcE  output  1  branch taken; fetch selects PCTargetE.
- PCTargetE  output  32  branch target.
- RegWriteM, MemWriteM, ResultSrcM  output  1  registered controls.
- RD_M  output  5  registered destination index.
- ALUResultM  output  32  registered ALU result.
- WriteDataM  output  32  registered store data (the forwarded RD2).
- PCPlus4M  output  32  registered PC+4.

## Operation
- Forward mux A (SrcA) and forward mux B (WriteDataE): 00 selects RD1_E/RD2_E; 01 selects ResultW; 10 selects ALUResultM; 11 behaves as 00.
- SrcB = ALUSrcE ? Imm_Ext_E : WriteDataE.
- ALU, 32-bit, carries discarded:
  - 000 add.
  - 001 sub (SrcA + ~SrcB + 1).
  - 010 and.
  - 011 or.
  - 101 slt, signed; result is {31'b0, lt}.
  - Any other code gives 0.
- signed lt = sign of (SrcA − SrcB) XOR signed overflow of the subtraction.
- ZeroE = (ALUResultE == 0).
- PCSrcE = BranchE & ZeroE.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^32.
- E/M register captures RegWriteE, MemWriteE, ResultSrcE, RD_E, ALUResultE, WriteDataE and PCPlus4E every cycle. No enable and no flush: bubbles arrive as zeroed controls from upstream.
- RS1_E and RS2_E are not registered.

## Timing
- PCSrcE and PCTargetE are combinational from the E inputs in the same cycle. They are valid before the rising edge that loads fetch.
- The ALU result appears on ALUResultM one cycle after the E inputs are presented.
- Forward path 10 uses ALUResultM as currently held, i.e. the previous instruction's result. This gives back-to-back forwarding with no stall.
- Reset, asynchronous and active-high:
  - Every M output goes to 0 immediately on rst assertion and holds at 0 while rst is 1.
  - The first capture happens on the first rising edge after deassertion.
  - Reset asserted mid-operation discards the in-flight instruction; no partial write can reach memory.
- Combinational outputs during reset follow the inputs. Fetch ignores PCSrcE while in reset.
- Wrap-around: PCE = 0xFFFFFFFC with Imm_Ext_E = 8 gives PCTargetE = 0x00000004.

## Test plan
- Reset: hold rst=1 with nonzero inputs and toggle clk -> all M outputs 0. Assert rst asynchronously between edges -> outputs clear before the next edge.
- add/sub/and/or/slt:
  - RD1=0x00000007, RD2=0xFFFFFFFE, ALUSrcE=0, codes 000/001/010/011/101 -> ALUResultM 0x00000005 / 0x00000009 / 0x00000006 / 0xFFFFFFFF / 0x00000000, each one cycle later.
  - Code 111 -> 0.
- slt overflow: SrcA=0x80000000, SrcB=0x00000001 -> 1. Swapped operands -> 0.
- Forwarding:
  - Cycle n: add with result 0x10.
  - Cycle n+1: ForwardAE=10, RD1=0x99, Imm=4, ALUSrcE=1 -> ALUResultM=0x14.
  - ForwardBE=01, ResultW=0xAB, MemWriteE=1 -> WriteDataM=0xAB.
- Branch:
  - BranchE=1, RD1=RD2=5, PCE=0x100, Imm=0xFFFFFFF0 -> PCSrcE=1 and PCTargetE=0xF0 in the same cycle.
  - RD2=6 -> PCSrcE=0.
  - PCE=0xFFFFFFFC with Imm=8 -> PCTargetE=0x4.
- Passthrough: RegWriteE=1, ResultSrcE=1, RD_E=0x1F, PCPlus4E=0x204 -> matching M values after one edge. Zeroed controls on the next cycle -> bubble appears in M.

Source files
------------

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the E/M pipeline register.
// Redirect (PCSrcE/PCTargetE) is combinational; M outputs follow one cycle later; no stall or flush, captures every cycle.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [4:0]  RS1_E,
    input  logic [4:0]  RS2_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    logic [31:0] src_a, write_data_e, src_b;
    logic [31:0] alu_result_e, diff;
    logic        ovf, lt, zero_e;

    logic        reg_write_d, reg_write_q;
    logic        mem_write_d, mem_write_q;
    logic        result_src_d, result_src_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] alu_result_d, alu_result_q;
    logic [31:0] write_data_d, write_data_q;
    logic [31:0] pc_plus4_d, pc_plus4_q;

    // Forward select 10 takes the result currently held in E/M (previous instruction).
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
        case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = alu_result_q;
            default: write_data_e = RD2_E;
        endcase
        src_b = ALUSrcE ? Imm_Ext_E : write_data_e;
    end

    // Signed less-than from the subtractor: sign of difference corrected by overflow.
    always_comb begin
        diff = src_a + ~src_b + 32'd1;
        ovf  = (src_a[31] != src_b[31]) && (diff[31] != src_a[31]);
        lt   = diff[31] ^ ovf;
        case (ALUControlE)
            3'b000:  alu_result_e = src_a + src_b;
            3'b001:  alu_result_e = diff;
            3'b010:  alu_result_e = src_a & src_b;
            3'b011:  alu_result_e = src_a | src_b;
            3'b101:  alu_result_e = {31'b0, lt};
            default: alu_result_e = 32'd0;
        endcase
        zero_e = (alu_result_e == 32'd0);
    end

    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        alu_result_d = alu_result_e;
        write_data_d = write_data_e;
        pc_plus4_d   = PCPlus4E;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= 5'd0;
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            pc_plus4_q   <= 32'd0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle with an arithmetic reference model checked every cycle.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E, RS1_E, RS2_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    int checks = 0;
    int errors = 0;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                          input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'd1) return w;
        if (sel == 2'd2) return m;
        return rf;
    endfunction

    // Reference model state: what the M stage must hold.
    logic        e_rw = 0, e_mw = 0, e_rs = 0;
    logic [4:0]  e_rd = 0;
    logic [31:0] e_alu = 0, e_wd = 0, e_pc4 = 0;

    always @(posedge clk or posedge rst) begin
        logic [31:0] a, wd, r;
        if (rst) begin
            e_rw = 0; e_mw = 0; e_rs = 0; e_rd = 0; e_alu = 0; e_wd = 0; e_pc4 = 0;
        end else begin
            a  = m_fwd(ForwardAE, RD1_E, ResultW, e_alu);
            wd = m_fwd(ForwardBE, RD2_E, ResultW, e_alu);
            r  = m_alu(ALUControlE, a, ALUSrcE ? Imm_Ext_E : wd);
            e_rw = RegWriteE; e_mw = MemWriteE; e_rs = ResultSrcE; e_rd = RD_E;
            e_alu = r; e_wd = wd; e_pc4 = PCPlus4E;
        end
    end

    always @(negedge clk) begin
        logic [31:0] a, wd, r;
        a  = m_fwd(ForwardAE, RD1_E, ResultW, e_alu);
        wd = m_fwd(ForwardBE, RD2_E, ResultW, e_alu);
        r  = m_alu(ALUControlE, a, ALUSrcE ? Imm_Ext_E : wd);
        chk("cyc_PCSrcE", {31'b0, PCSrcE}, {31'b0, BranchE && (r == 32'd0)});
        chk("cyc_PCTargetE", PCTargetE, PCE + Imm_Ext_E);
        chk("cyc_RegWriteM", {31'b0, RegWriteM}, {31'b0, e_rw});
        chk("cyc_MemWriteM", {31'b0, MemWriteM}, {31'b0, e_mw});
        chk("cyc_ResultSrcM", {31'b0, ResultSrcM}, {31'b0, e_rs});
        chk("cyc_RD_M", {27'b0, RD_M}, {27'b0, e_rd});
        chk("cyc_ALUResultM", ALUResultM, e_alu);
        chk("cyc_WriteDataM", WriteDataM, e_wd);
        chk("cyc_PCPlus4M", PCPlus4M, e_pc4);
    end

    task automatic clear_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'd0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        RS1_E = 0; RS2_E = 0; PCE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0;
        ResultW = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, "_RegWriteM"}, {31'b0, RegWriteM}, 32'd0);
        chk({tag, "_MemWriteM"}, {31'b0, MemWriteM}, 32'd0);
        chk({tag, "_ResultSrcM"}, {31'b0, ResultSrcM}, 32'd0);
        chk({tag, "_RD_M"}, {27'b0, RD_M}, 32'd0);
        chk({tag, "_ALUResultM"}, ALUResultM, 32'd0);
        chk({tag, "_WriteDataM"}, WriteDataM, 32'd0);
        chk({tag, "_PCPlus4M"}, PCPlus4M, 32'd0);
    endtask

    logic [31:0] alu_exp [5] = '{32'h5, 32'h9, 32'h6, 32'hFFFFFFFF, 32'h0};
    logic [2:0]  alu_ops [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

    initial begin
        clear_inputs();
        // Nonzero inputs while reset is held.
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd9; RD1_E = 32'h11;
        RD2_E = 32'h22; PCPlus4E = 32'h44; PCE = 32'h40; Imm_Ext_E = 32'h8;
        repeat (3) tick();
        chk_m_zero("rst_hold");
        rst = 0;
        clear_inputs();

        for (int i = 0; i < 5; i++) begin
            RD1_E = 32'h7; RD2_E = 32'hFFFFFFFE; ALUControlE = alu_ops[i];
            tick();
            chk($sformatf("alu_op%0d", alu_ops[i]), ALUResultM, alu_exp[i]);
        end
        ALUControlE = 3'd7;
        tick();
        chk("alu_op7", ALUResultM, 32'h0);

        ALUControlE = 3'd5; RD1_E = 32'h80000000; RD2_E = 32'h1;
        tick();
        chk("slt_ovf", ALUResultM, 32'h1);
        RD1_E = 32'h1; RD2_E = 32'h80000000;
        tick();
        chk("slt_swap", ALUResultM, 32'h0);

        clear_inputs();
        RD1_E = 32'h8; RD2_E = 32'h8;
        tick();
        chk("fwd_prod", ALUResultM, 32'h10);
        ForwardAE = 2'b10; RD1_E = 32'h99; Imm_Ext_E = 32'h4; ALUSrcE = 1;
        ForwardBE = 2'b01; ResultW = 32'hAB; MemWriteE = 1; RD2_E = 32'h55;
        tick();
        chk("fwd_a_mem", ALUResultM, 32'h14);
        chk("fwd_b_wb", WriteDataM, 32'hAB);
        chk("fwd_memwrite", {31'b0, MemWriteM}, 32'd1);

        clear_inputs();
        BranchE = 1; ALUControlE = 3'd1; RD1_E = 32'h5; RD2_E = 32'h5;
        PCE = 32'h100; Imm_Ext_E = 32'hFFFFFFF0;
        #1;
        chk("br_taken", {31'b0, PCSrcE}, 32'd1);
        chk("br_target", PCTargetE, 32'hF0);
        RD2_E = 32'h6;
        #1;
        chk("br_not_taken", {31'b0, PCSrcE}, 32'd0);
        PCE = 32'hFFFFFFFC; Imm_Ext_E = 32'h8;
        #1;
        chk("br_wrap", PCTargetE, 32'h4);
        tick();

        clear_inputs();
        RegWriteE = 1; ResultSrcE = 1; RD_E = 5'h1F; PCPlus4E = 32'h204;
        RD1_E = 32'h3; RD2_E = 32'h4;
        tick();
        chk("pass_RegWriteM", {31'b0, RegWriteM}, 32'd1);
        chk("pass_ResultSrcM", {31'b0, ResultSrcM}, 32'd1);
        chk("pass_RD_M", {27'b0, RD_M}, 32'h1F);
        chk("pass_PCPlus4M", PCPlus4M, 32'h204);
        chk("pass_ALUResultM", ALUResultM, 32'h7);
        clear_inputs();
        tick();
        chk_m_zero("bubble");

        // Asynchronous reset between edges discards an in-flight store.
        MemWriteE = 1; RegWriteE = 1; RD_E = 5'd3; RD1_E = 32'h1234; RD2_E = 32'h77;
        PCPlus4E = 32'h88;
        @(posedge clk);
        #2;
        chk("pre_arst_MemWriteM", {31'b0, MemWriteM}, 32'd1);
        rst = 1;
        #1;
        chk_m_zero("arst");
        tick();
        rst = 0;
        clear_inputs();
        RD1_E = 32'h20; RD2_E = 32'h5; ALUControlE = 3'd1; RD_E = 5'd2;
        tick();
        chk("post_rst_first", ALUResultM, 32'h1B);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
